// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters; IF looks up combinationally, EX updates.
// Define BP_STATS_EN to add saturating branch/mispredict statistics counters.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_next_pc,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc[2 +: IDX_W];
  assign lk_tag = lookup_pc[2 + IDX_W +: TAG_W];
  assign up_idx = update_pc[2 +: IDX_W];
  assign up_tag = update_pc[2 + IDX_W +: TAG_W];
  assign unused_pc_bits = ^{lookup_pc, update_pc};

  assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken   = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign mispredict = update_valid &&
                      ((update_taken != update_pred_taken) ||
                       (update_taken && (update_pred_next_pc != update_target)));

  // Tags and targets are deliberately left out of reset; valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (update_valid) begin
      if (update_taken) begin
        if (up_hit) begin
          if (ctr_q[up_idx] != CTR_MAX)
            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
          target_q[up_idx] <= update_target;
        end else begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= update_target;
          ctr_q[up_idx]    <= CTR_WT;
        end
      end else if (up_hit && (ctr_q[up_idx] != '0)) begin
        ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update_valid && (stat_branches != '1))
        stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`else
  localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: reset, allocation, hysteresis, aliasing, hazards.
// Define BP_STATS_EN to also exercise the statistics counters (built with STAT_W=4).
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_next_pc;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;
`endif

  int num_asserts = 0;
  int num_fails   = 0;

  branch_predictor_btb #(
    .XLEN(32), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc),
    .update_valid(update_valid),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target),
    .update_pred_taken(update_pred_taken),
    .update_pred_next_pc(update_pred_next_pc),
    .mispredict(mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic upt,
                               input logic [31:0] upnpc);
    lookup_pc           = lpc;
    update_valid        = uv;
    update_pc           = upc;
    update_taken        = ut;
    update_target       = utgt;
    update_pred_taken   = upt;
    update_pred_next_pc = upnpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_asserts++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idleLookup(input logic [31:0] lpc);
    applyStimulus(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idleLookup(32'h0);
    tick();
    tick();
    checkOutput("hit_during_reset", {31'b0, pred_hit}, 32'd0);
    rst = 1'b0;

    // Empty table: every address misses and falls through to pc+4.
    for (int a = 0; a <= 32'h3C; a += 4) begin
      idleLookup(32'(a));
      checkOutput("reset_hit", {31'b0, pred_hit}, 32'd0);
      checkOutput("reset_taken", {31'b0, pred_taken}, 32'd0);
      checkOutput("reset_next", pred_next_pc, 32'(a) + 32'd4);
    end
    idleLookup(32'hFFFF_FFFC);
    checkOutput("wrap_next", pred_next_pc, 32'h0000_0000);

    // Allocation of 0x18 -> 0x24 (ctr becomes 10).
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h24, 1'b0, 32'h1C);
    checkOutput("alloc_mispredict", {31'b0, mispredict}, 32'd1);
    checkOutput("alloc_preupdate_hit", {31'b0, pred_hit}, 32'd0);
    tick();
    idleLookup(32'h18);
    checkOutput("alloc_hit", {31'b0, pred_hit}, 32'd1);
    checkOutput("alloc_taken", {31'b0, pred_taken}, 32'd1);
    checkOutput("alloc_next", pred_next_pc, 32'h24);

    // Hysteresis: 10 -> 01 -> 00 -> 00.
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b0, 32'h24, 1'b1, 32'h24);
    checkOutput("nt_mispredict", {31'b0, mispredict}, 32'd1);
    tick();
    idleLookup(32'h18);
    checkOutput("ctr01_hit", {31'b0, pred_hit}, 32'd1);
    checkOutput("ctr01_taken", {31'b0, pred_taken}, 32'd0);
    checkOutput("ctr01_next", pred_next_pc, 32'h1C);
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b0, 32'h24, 1'b0, 32'h1C);
    checkOutput("nt_correct", {31'b0, mispredict}, 32'd0);
    tick();
    tick();
    idleLookup(32'h18);
    checkOutput("ctr00_taken", {31'b0, pred_taken}, 32'd0);

    // Four taken updates: 00 -> 01 -> 10 -> 11 -> 11.
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h24, 1'b0, 32'h1C);
    for (int k = 0; k < 4; k++) tick();
    idleLookup(32'h18);
    checkOutput("ctr11_taken", {31'b0, pred_taken}, 32'd1);

    // Right direction but wrong target still counts as a mispredict.
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h24, 1'b1, 32'h30);
    checkOutput("wrong_target_mispredict", {31'b0, mispredict}, 32'd1);
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h24, 1'b1, 32'h24);
    checkOutput("right_target_no_mispredict", {31'b0, mispredict}, 32'd0);

    // A single not-taken from 11 leaves the prediction taken (ctr 10).
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b0, 32'h24, 1'b1, 32'h24);
    tick();
    idleLookup(32'h18);
    checkOutput("ctr10_taken", {31'b0, pred_taken}, 32'd1);
    checkOutput("ctr10_next", pred_next_pc, 32'h24);

    // Aliasing: 0x58 shares index 6 with 0x18 but has tag 1.
    applyStimulus(32'h18, 1'b1, 32'h58, 1'b1, 32'h80, 1'b0, 32'h5C);
    tick();
    idleLookup(32'h18);
    checkOutput("alias_old_hit", {31'b0, pred_hit}, 32'd0);
    checkOutput("alias_old_next", pred_next_pc, 32'h1C);
    idleLookup(32'h58);
    checkOutput("alias_new_hit", {31'b0, pred_hit}, 32'd1);
    checkOutput("alias_new_next", pred_next_pc, 32'h80);
    applyStimulus(32'h58, 1'b1, 32'h98, 1'b0, 32'hA0, 1'b0, 32'h9C);
    tick();
    idleLookup(32'h58);
    checkOutput("nt_miss_keep_hit", {31'b0, pred_hit}, 32'd1);
    checkOutput("nt_miss_keep_next", pred_next_pc, 32'h80);
    idleLookup(32'h98);
    checkOutput("nt_miss_no_alloc", {31'b0, pred_hit}, 32'd0);

    // Same-cycle lookup and update: old state now, new state next cycle.
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h24, 1'b0, 32'h1C);
    tick();
    applyStimulus(32'h18, 1'b1, 32'h18, 1'b1, 32'h40, 1'b1, 32'h24);
    checkOutput("hazard_old_next", pred_next_pc, 32'h24);
    tick();
    idleLookup(32'h18);
    checkOutput("hazard_new_next", pred_next_pc, 32'h40);

    // Reset with a concurrent update: update dropped, mispredict not gated.
    rst = 1'b1;
    applyStimulus(32'h58, 1'b1, 32'h58, 1'b1, 32'h80, 1'b0, 32'h5C);
    checkOutput("rst_mispredict_ungated", {31'b0, mispredict}, 32'd1);
    tick();
    checkOutput("rst_hit_during", {31'b0, pred_hit}, 32'd0);
    rst = 1'b0;
    idleLookup(32'h58);
    checkOutput("rst_drop_hit", {31'b0, pred_hit}, 32'd0);
    checkOutput("rst_drop_next", pred_next_pc, 32'h5C);
    idleLookup(32'h18);
    checkOutput("rst_clear_hit", {31'b0, pred_hit}, 32'd0);
    checkOutput("rst_clear_next", pred_next_pc, 32'h1C);

`ifdef BP_STATS_EN
    checkOutput("stat_br_reset", {28'b0, stat_branches}, 32'd0);
    checkOutput("stat_mp_reset", {28'b0, stat_mispredicts}, 32'd0);
    // 10 not-taken misses; three of them were predicted taken.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(32'h0, 1'b1, 32'h100, 1'b0, 32'h200, (k < 3), 32'h104);
      tick();
    end
    idleLookup(32'h0);
    checkOutput("stat_br_10", {28'b0, stat_branches}, 32'd10);
    checkOutput("stat_mp_3", {28'b0, stat_mispredicts}, 32'd3);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(32'h0, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
      tick();
    end
    idleLookup(32'h0);
    checkOutput("stat_br_sat", {28'b0, stat_branches}, 32'd15);
    checkOutput("stat_mp_hold", {28'b0, stat_mispredicts}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stat_br_clear", {28'b0, stat_branches}, 32'd0);
    checkOutput("stat_mp_clear", {28'b0, stat_mispredicts}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor: a direct-mapped branch target buffer (BTB) with one saturating counter per entry.
- Replaces the static "branch resolved in EX via Branch_Adder + AND" scheme.
- IF stage issues a combinational lookup on the current PC and receives a predicted next PC.
- EX stage reports resolved branches through the update port one cycle later; the table learns from those updates.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; must satisfy 2+IDX_W+TAG_W <= XLEN.
- CTR_W, 2, saturating counter width (at least 1).
- STAT_W, 16, statistics counter width (used only with BP_STATS_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  XLEN  PC of the instruction being fetched.
- pred_hit  output  1  lookup_pc matches a valid entry.
- pred_taken  output  1  prediction is taken.
- pred_next_pc  output  XLEN  predicted next PC.
- update_valid  input  1  a resolved branch is presented this cycle.
- update_pc  input  XLEN  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.
- update_target  input  XLEN  actual branch target (PC + B-immediate).
- update_pred_taken  input  1  prediction made for this branch at fetch.
- update_pred_next_pc  input  XLEN  pred_next_pc made for this branch at fetch.
- mispredict  output  1  combinational; high when update_valid and the prediction was wrong.
- stat_branches  output  STAT_W  (BP_STATS_EN only) resolved branches counted.
- stat_mispredicts  output  STAT_W  (BP_STATS_EN only) mispredictions counted.

Behaviour:
- Address mapping: idx = pc[2 +: IDX_W]; tag = pc[2+IDX_W +: TAG_W]; pc[1:0] ignored.
- Entry state: valid (1 bit), tag (TAG_W), target (XLEN), ctr (CTR_W).
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken = pred_hit & ctr[idx][CTR_W-1].
  - pred_next_pc = pred_taken ? target[idx] : lookup_pc + 4, wrapping modulo 2^XLEN.
- Mispredict: mispredict = update_valid & ((update_taken != update_pred_taken) | (update_taken & update_pred_next_pc != update_target)).
- Update, registered at the clk edge when update_valid=1. Hit/miss is judged against update_pc.
  - Hit, taken: ctr increments, saturating at all-ones; target <= update_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate/overwrite the entry: valid=1, tag written, target=update_target, ctr=weakly-taken (MSB=1, others 0; 2'b10 when CTR_W=2).
  - Miss, not taken: no table change.
- Simultaneous lookup and update of the same index in one cycle: lookup returns the pre-update state. No bypass; the new state is visible the next cycle.
- Reset (rst=1 at the clk edge), including mid-operation:
  - All valid bits clear and all ctr = weakly-not-taken (MSB=0, others 1; 2'b01 when CTR_W=2).
  - Tags and targets need not be cleared.
  - A concurrent update is discarded.
- Output values while and after reset:
  - pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.
  - mispredict is combinational and is not gated by rst.
  - Stats outputs = 0.
- update_valid=0: state holds.

Optional Feature:
- Macro BP_STATS_EN.
- When defined:
  - stat_branches increments on each update_valid.
  - stat_mispredicts increments on each cycle where mispredict is high.
  - Both saturate at all-ones (no wrap) and clear on rst.
- When not defined: stat ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset test: rst for 2 cycles, then sweep lookup_pc 0x0..0x3C -> pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4 at every address.
- Allocation: update pc=0x18, taken=1, target=0x24, pred_taken=0 -> mispredict=1 that cycle. Next cycle lookup 0x18 -> hit=1, taken=1, next_pc=0x24.
- Counter hysteresis: from the allocated state (ctr=10), apply not-taken updates.
  - After 1 update: ctr=01, lookup 0x18 -> taken=0, next_pc=0x1C.
  - After 2 more updates: ctr saturates at 00.
  - 4 taken updates: ctr saturates at 11; a single not-taken still predicts taken.
- Aliasing (ENTRIES=16): allocate 0x18 (taken to 0x24), then update pc=0x58 taken to 0x80 -> lookup 0x18 hit=0, lookup 0x58 next_pc=0x80. A not-taken miss on 0x98 leaves the entry unchanged.
- Same-cycle hazard: lookup 0x18 while an update to 0x18 is in flight -> old prediction that cycle, new prediction the following cycle. rst asserted together with update_valid -> table empty afterwards.
- BP_STATS_EN: 10 updates, 3 mispredicted -> stat_branches=10, stat_mispredicts=3. With STAT_W=4, 20 updates -> stat_branches holds at 15.
